// File: rtl/wordboard_seq_pkg.sv
// Shared constants for the word-board serial player: FSM state encoding and frame line levels.
package wordboard_seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/wordboard_seq_debounce.sv
// Button debouncer: two-flop synchronizer, stability counter, one-clock pulse on clean 0->1.
module debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic sysclk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;

   // Any sample that agrees with the clean level restarts the stability window.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            level_d = sync_q[1];
            press_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/wordboard_seq.sv
// Word buffer filled from switches, played back as serial frames (start, data MSB-first, stop).
module wordboard_seq
   import wordboard_seq_pkg::*;
#(
   parameter int SW_W       = 4,
   parameter int DEPTH      = 8,
   parameter int DEB_CYCLES = 50000,
   parameter int BIT_CYCLES = 2500000
) (
   input  logic                     sysclk,
   input  logic                     reset,
   input  logic [SW_W-1:0]          sw,
   input  logic                     btn_write,
   input  logic                     btn_auto,
   input  logic                     btn_clear,
   input  logic                     loop,
   output logic                     out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     full
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);
   localparam int BW = $clog2(BIT_CYCLES + 1);
   localparam int DW = $clog2(SW_W + 1);

   logic [2:0] btn_raw, btn_pulse, btn_level_unused;
   logic       wr_p, auto_p, clr_p;

   assign btn_raw = {btn_clear, btn_auto, btn_write};

   for (genvar b = 0; b < 3; b++) begin : g_deb
      debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .sysclk  (sysclk),
         .reset   (reset),
         .raw_i   (btn_raw[b]),
         .level_o (btn_level_unused[b]),
         .press_o (btn_pulse[b])
      );
   end

   assign {clr_p, auto_p, wr_p} = btn_pulse;

   logic [SW_W-1:0] mem_q [DEPTH];
   logic [CW-1:0]   count_q, count_d;
   logic [IW-1:0]   rd_q, rd_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [DW-1:0]   bidx_q, bidx_d;
   logic [1:0]      state_q, state_d;
   logic            out_q, out_d;
   logic            wr_ok, bit_end;
   logic [SW_W-1:0] rd_word;

   assign full    = (count_q == CW'(DEPTH));
   assign wr_ok   = wr_p && !full;
   assign bit_end = (bcnt_q == BW'(BIT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clr_p && state_q == ST_IDLE) count_d = '0;
      else if (wr_ok)                  count_d = count_q + CW'(1);
   end

   // Auto start looks at count_d so a write landing on the same clock counts.
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      bidx_d  = bidx_q;
      bcnt_d  = bit_end ? '0 : bcnt_q + BW'(1);
      case (state_q)
         ST_IDLE: begin
            bcnt_d = '0;
            if (auto_p && count_d != '0) begin
               state_d = ST_START;
               rd_d    = '0;
               bidx_d  = '0;
            end
         end
         ST_START: if (bit_end) begin
            state_d = ST_DATA;
            bidx_d  = '0;
         end
         ST_DATA: if (bit_end) begin
            if (bidx_q == DW'(SW_W - 1)) state_d = ST_STOP;
            else                         bidx_d  = bidx_q + DW'(1);
         end
         default: if (bit_end) begin
            if (CW'(rd_q) + CW'(1) < count_q) begin
               rd_d    = rd_q + IW'(1);
               state_d = ST_START;
            end else if (loop) begin
               rd_d    = '0;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
      if (auto_p && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         bcnt_d  = '0;
      end
   end

   assign rd_word = mem_q[rd_d];

   always_comb begin
      case (state_d)
         ST_START: out_d = START_BIT;
         ST_DATA:  out_d = rd_word[DW'(SW_W - 1) - bidx_d];
         default:  out_d = STOP_BIT;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (wr_ok && !(clr_p && state_q == ST_IDLE)) mem_q[count_q[IW-1:0]] <= sw;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         rd_q    <= '0;
         bcnt_q  <= '0;
         bidx_q  <= '0;
         out_q   <= STOP_BIT;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         bcnt_q  <= bcnt_d;
         bidx_q  <= bidx_d;
         out_q   <= out_d;
      end
   end

   assign out   = out_q;
   assign count = count_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wordboard_seq.sv
// Directed bench for wordboard_seq with short debounce and bit periods.
module tb_wordboard_seq;

   localparam int SW_W = 4;
   localparam int DEPTH = 4;
   localparam int DEB_CYCLES = 4;
   localparam int BIT_CYCLES = 3;

   logic            sysclk = 1'b0;
   logic            reset;
   logic [SW_W-1:0] sw;
   logic            btn_write, btn_auto, btn_clear, loop;
   logic            out, busy, full;
   logic [2:0]      count;

   int nvec = 0;
   int nerr = 0;

   always #5 sysclk = ~sysclk;

   wordboard_seq #(
      .SW_W(SW_W), .DEPTH(DEPTH), .DEB_CYCLES(DEB_CYCLES), .BIT_CYCLES(BIT_CYCLES)
   ) dut (
      .sysclk(sysclk), .reset(reset), .sw(sw), .btn_write(btn_write),
      .btn_auto(btn_auto), .btn_clear(btn_clear), .loop(loop),
      .out(out), .count(count), .busy(busy), .full(full)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge sysclk);
      #1;
   endtask

   task automatic press_write(input logic [SW_W-1:0] w);
      sw = w;
      btn_write = 1'b1;
      repeat (10) tick;
      btn_write = 1'b0;
      repeat (10) tick;
   endtask

   task automatic press_clear;
      btn_clear = 1'b1;
      repeat (10) tick;
      btn_clear = 1'b0;
      repeat (10) tick;
   endtask

   task automatic wait_busy(input logic want, input string tag);
      for (int i = 0; i < 20 && busy !== want; i++) tick;
      chk(tag, busy, want);
   endtask

   task automatic start_auto(input string tag);
      btn_auto = 1'b1;
      wait_busy(1'b1, tag);
      btn_auto = 1'b0;
   endtask

   task automatic stop_auto(input string tag);
      btn_auto = 1'b1;
      wait_busy(1'b0, tag);
      chk({tag, "_out"}, out, 0);
      btn_auto = 1'b0;
      repeat (10) tick;
   endtask

   // Checks one full frame, starting at its first START cycle.
   task automatic expect_frame(input logic [SW_W-1:0] w, input string tag);
      logic [5:0] bits;
      bits = {1'b1, w, 1'b0};
      for (int i = 0; i < 18; i++) begin
         chk(tag, out, bits[5 - i / 3]);
         tick;
      end
   endtask

   initial begin
      reset = 1'b1; sw = '0; btn_write = 0; btn_auto = 0; btn_clear = 0; loop = 0;
      repeat (3) tick;
      chk("rst_out", out, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      reset = 1'b0;
      tick;

      // bouncing write button yields exactly one write
      sw = 4'b1010;
      btn_write = 1; tick; btn_write = 0; tick; btn_write = 1;
      repeat (10) tick;
      btn_write = 0;
      repeat (10) tick;
      chk("bounce_count", count, 1);

      // single-shot playback of 1010
      loop = 0;
      start_auto("play1_start");
      expect_frame(4'b1010, "play1_frame");
      chk("play1_busy_end", busy, 0);
      chk("play1_out_end", out, 0);
      repeat (10) tick;

      // clear while idle, then auto with empty buffer
      press_clear;
      chk("clr_idle_count", count, 0);
      btn_auto = 1; repeat (12) tick;
      chk("auto_empty_busy", busy, 0);
      btn_auto = 0; repeat (10) tick;
      chk("auto_empty_busy2", busy, 0);

      // fill past capacity; fifth word dropped
      press_write(4'hA); press_write(4'hB); press_write(4'hC); press_write(4'hD);
      chk("fill_count", count, 4);
      chk("fill_full", full, 1);
      press_write(4'hE);
      chk("over_count", count, 4);
      chk("over_full", full, 1);
      start_auto("fill_start");
      expect_frame(4'hA, "fill_f0");
      expect_frame(4'hB, "fill_f1");
      expect_frame(4'hC, "fill_f2");
      expect_frame(4'hD, "fill_f3");
      chk("fill_busy_end", busy, 0);
      repeat (10) tick;
      press_clear;
      chk("clr2_count", count, 0);
      chk("clr2_full", full, 0);

      // simultaneous write and auto with empty buffer
      sw = 4'h6;
      btn_write = 1; btn_auto = 1;
      wait_busy(1'b1, "sim_busy");
      chk("sim_count", count, 1);
      btn_write = 0; btn_auto = 0;
      expect_frame(4'h6, "sim_frame");
      chk("sim_busy_end", busy, 0);
      repeat (10) tick;
      press_clear;

      // two words looping, stopped mid-DATA by a second auto press
      press_write(4'hC); press_write(4'h3);
      loop = 1;
      start_auto("loop_start");
      expect_frame(4'hC, "loop_f0");
      expect_frame(4'h3, "loop_f1");
      expect_frame(4'hC, "loop_f2");
      expect_frame(4'h3, "loop_f3");
      repeat (3) begin
         chk("loop_f4_start", out, 1);
         tick;
      end
      stop_auto("loop_stop");
      chk("loop_stay_idle", busy, 0);

      // clear ignored while busy
      start_auto("clrbusy_start");
      press_clear;
      chk("clrbusy_count", count, 2);
      chk("clrbusy_busy", busy, 1);
      stop_auto("clrbusy_stop");
      press_clear;
      chk("clr3_count", count, 0);
      chk("clr3_full", full, 0);

      // reset in the middle of a data bit
      loop = 0;
      press_write(4'h9);
      start_auto("rstmid_start");
      repeat (5) tick;
      chk("rstmid_in_frame", busy, 1);
      reset = 1;
      tick;
      chk("rstmid_out", out, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_count", count, 0);
      reset = 0;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
